// File: rtl/step_sequencer_pkg.sv
// Shared step-sequencer definitions: 3-bit FSM state encoding and the 8-entry
// half-step coil phase table ({A,B,C,D}, active-high), reused by other coil drivers.
// Even indices energise one coil (wave drive); odd indices energise two (two-phase drive).
package step_sequencer_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE    = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_ON  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_OFF = 3'd3;
  localparam logic [STATE_W-1:0] ST_ADVANCE  = 3'd4;
  localparam logic [STATE_W-1:0] ST_FIN      = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = ST_IDLE,
    S_ISSUE    = ST_ISSUE,
    S_WAIT_ON  = ST_WAIT_ON,
    S_WAIT_OFF = ST_WAIT_OFF,
    S_ADVANCE  = ST_ADVANCE,
    S_FIN      = ST_FIN
  } state_e;

  // Element [i] is the coil pattern for phase index i (element 0 is the rightmost).
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    return PHASE_TABLE[idx];
  endfunction

endpackage

// File: rtl/step_sequencer_phase_lut.sv
// Phase lookup: maps a 3-bit phase index to the 4-bit coil pattern.
// Purely combinational, zero latency, no flow control.
// Ports: idx_i phase index in; coil_o {A,B,C,D} pattern out.
module step_sequencer_phase_lut
  import step_sequencer_pkg::*;
(
  input  logic [2:0] idx_i,
  output logic [3:0] coil_o
);

  assign coil_o = phase_of(idx_i);

endmodule

// File: rtl/step_sequencer.sv
// Step sequencer: issues start pulses to a step timer, waits out each 'on' window,
// then advances the coil phase; runs n_steps and pulses done (or flags err on timeout).
// Latency: registered coil follows the phase index the cycle after ADVANCE.
// Backpressure: go is only honoured in IDLE; the timer paces each step via tmr_on.
// Ports: spd_i clock, rst_i async active-low reset; go_i/n_steps_i/dir_i/hs_i run request
//   (latched on accept); hold_i keeps coils energised when idle; tmr_on_i timer window;
//   tmr_start_o timer start; coil_o coil drive; busy_o, done_o (pulse), err_o (sticky).
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic             spd_i,
  input  logic             rst_i,
  input  logic             go_i,
  input  logic [CNT_W-1:0] n_steps_i,
  input  logic             dir_i,
  input  logic             hs_i,
  input  logic             hold_i,
  input  logic             tmr_on_i,
  output logic             tmr_start_o,
  output logic [3:0]       coil_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             hs_q, hs_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       coil_q, coil_d;
  logic [3:0]       lut_coil;
  logic [2:0]       step_sz;

  // Looked up from the next index so the coil register lands together with idx.
  step_sequencer_phase_lut u_phase_lut (
    .idx_i  (idx_d),
    .coil_o (lut_coil)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    hs_d    = hs_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    step_sz = hs_q ? 3'd1 : 3'd2;
    case (state_q)
      S_IDLE: begin
        if (go_i) begin
          if (n_steps_i != '0) begin
            rem_d   = n_steps_i;
            dir_d   = dir_i;
            hs_d    = hs_i;
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end else begin
            // Zero-length request: acknowledge with done, never touch the timer.
            state_d = S_FIN;
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_ON;
      end
      S_WAIT_ON: begin
        if (tmr_on_i) begin
          state_d = S_WAIT_OFF;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          rem_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_OFF: begin
        if (!tmr_on_i) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        // 3-bit arithmetic gives the mod-8 wrap in both directions.
        idx_d   = dir_q ? (idx_q + step_sz) : (idx_q - step_sz);
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == CNT_W'(1)) ? S_FIN : S_ISSUE;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    coil_d = lut_coil;
    if (state_d == S_IDLE && !hold_i) begin
      coil_d = 4'b0000;
    end else if (state_q == S_IDLE && state_d == S_FIN) begin
      // A zero-step request leaves the coils exactly as they were.
      coil_d = coil_q;
    end
  end

  always_ff @(posedge spd_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      hs_q    <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      coil_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      hs_q    <= hs_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      coil_q  <= coil_d;
    end
  end

  assign tmr_start_o = (state_q == S_ISSUE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FIN);
  assign err_o       = err_q;
  assign coil_o      = coil_q;

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

  localparam int CW  = 4;
  localparam int TMO = 200;

  logic          spd_i = 1'b0;
  logic          rst_i;
  logic          go_i;
  logic [CW-1:0] n_steps_i;
  logic          dir_i;
  logic          hs_i;
  logic          hold_i;
  logic          tmr_on_i;
  logic          tmr_start_o;
  logic [3:0]    coil_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  step_sequencer #(.CNT_W(CW), .TMO_W(8), .TMO_MAX(TMO)) dut (
    .spd_i       (spd_i),
    .rst_i       (rst_i),
    .go_i        (go_i),
    .n_steps_i   (n_steps_i),
    .dir_i       (dir_i),
    .hs_i        (hs_i),
    .hold_i      (hold_i),
    .tmr_on_i    (tmr_on_i),
    .tmr_start_o (tmr_start_o),
    .coil_o      (coil_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 spd_i = ~spd_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  logic [3:0] pat_tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                              4'b0010, 4'b0011, 4'b0001, 4'b1001};

  function automatic logic [3:0] pat(input int i);
    int k;
    k = ((i % 8) + 8) % 8;
    return pat_tab[k[2:0]];
  endfunction

  // Timer model: a start request seen in a cycle opens an on-window of win_len
  // cycles beginning the following cycle; when stuck it never responds.
  int on_left = 0;
  int win_len = 1;
  bit tmr_stuck = 0;
  always @(negedge spd_i) begin
    if (!rst_i) begin
      on_left  = 0;
      tmr_on_i = 1'b0;
    end else begin
      tmr_on_i = (on_left > 0);
      if (on_left > 0) on_left--;
      if (tmr_start_o && !tmr_stuck) on_left = win_len;
    end
  end

  // Run-level model: one run = go accepted, then n steps of (window+3) cycles each,
  // then a done cycle. r counts samples since the go cycle (r=0).
  bit chk_en = 0;
  bit m_run = 0;
  int m_r = 0, m_n = 0, m_len = 1, m_step = 1, m_idx = 0;
  bit m_stuck = 0, m_err = 0;
  bit hold_prev = 0;
  int cnt_start = 0, cnt_done = 0;
  bit log_en = 0;
  logic [3:0] coil_log [$];

  always @(negedge spd_i) begin
    int per, e_start, e_busy, e_done, e_err;
    logic [3:0] e_coil;
    bit end_run;
    if (chk_en) begin
      per = m_len + 3;
      e_start = 0; e_busy = 0; e_done = 0; e_err = m_err;
      e_coil = hold_prev ? pat(m_idx) : 4'b0000;
      end_run = 0;
      if (m_run && m_r >= 1) begin
        if (m_stuck) begin
          e_busy = 1; e_err = 0; e_start = (m_r == 1); e_coil = pat(m_idx);
          if (m_r == TMO + 1) end_run = 1;
        end else if (m_n == 0) begin
          e_busy = 1; e_done = 1; end_run = 1;
        end else if (m_r <= m_n * per) begin
          e_busy = 1; e_err = 0;
          e_start = ((m_r - 1) % per == 0);
          e_coil = pat(m_idx + ((m_r - 1) / per) * m_step);
        end else begin
          e_busy = 1; e_done = 1; e_err = 0;
          e_coil = pat(m_idx + m_n * m_step);
          end_run = 1;
        end
      end
      chk("coil", int'(coil_o), int'(e_coil));
      chk("busy", int'(busy_o), e_busy);
      chk("done", int'(done_o), e_done);
      chk("tmr_start", int'(tmr_start_o), e_start);
      chk("err", int'(err_o), e_err);
      if (tmr_start_o) cnt_start++;
      if (done_o) cnt_done++;
      if (log_en && (coil_log.size() == 0 || coil_log[$] != coil_o)) coil_log.push_back(coil_o);
      if (m_run) m_r++;
      if (end_run) begin
        m_run = 0;
        if (m_stuck) m_err = 1;
        else if (m_n != 0) begin
          m_err = 0;
          m_idx = ((m_idx + m_n * m_step) % 8 + 8) % 8;
        end
      end
    end
    hold_prev = hold_i;
  end

  task automatic start_run(input int n, input bit d, input bit h, input int len, input bit stuck);
    cnt_start = 0;
    cnt_done  = 0;
    @(posedge spd_i); #1;
    m_n = n; m_len = len; m_stuck = stuck;
    m_step = (d ? 1 : -1) * (h ? 1 : 2);
    m_r = 0; m_run = 1;
    win_len = len; tmr_stuck = stuck;
    go_i = 1'b1; n_steps_i = CW'(n); dir_i = d; hs_i = h;
    @(posedge spd_i); #1;
    // Scramble the request inputs mid-run; the latched copies must be used.
    go_i = 1'b0; n_steps_i = CW'($urandom); dir_i = ~d; hs_i = ~h;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (m_run && n < budget) begin
      @(negedge spd_i);
      n++;
    end
    chk("run_completes", int'(m_run), 0);
    m_run = 0;
    repeat (3) @(negedge spd_i);
  endtask

  task automatic set_hold(input bit h);
    @(posedge spd_i); #1;
    hold_i = h;
    repeat (3) @(negedge spd_i);
  endtask

  task automatic check_log(input string nm, input int n, input logic [3:0] e0, e1, e2, e3, e4);
    logic [3:0] ex [5];
    ex = '{e0, e1, e2, e3, e4};
    chk({nm, "_len"}, coil_log.size(), n);
    for (int i = 0; i < n && i < coil_log.size(); i++)
      chk($sformatf("%s_%0d", nm, i), int'(coil_log[i]), int'(ex[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_i = 1'b0; go_i = 1'b0; n_steps_i = '0; dir_i = 1'b0; hs_i = 1'b0;
    hold_i = 1'b0; tmr_on_i = 1'b0;

    // Reset state
    repeat (3) @(negedge spd_i);
    chk("rst_coil", int'(coil_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_start", int'(tmr_start_o), 0);
    @(posedge spd_i); #2;
    rst_i = 1'b1;
    hold_i = 1'b1;
    @(posedge spd_i); #1;
    chk_en = 1;
    repeat (3) @(negedge spd_i);

    // 1: forward half-step, 3 steps, 50-cycle window
    coil_log.delete(); log_en = 1;
    start_run(3, 1'b1, 1'b1, 50, 1'b0);
    wait_idle(1000);
    log_en = 0;
    check_log("t1_coil", 4, 4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0000);
    chk("t1_starts", cnt_start, 3);
    chk("t1_dones", cnt_done, 1);
    chk("t1_busy_after", int'(busy_o), 0);

    // Move to idx 1 (reverse half-step 3->2->1)
    start_run(2, 1'b0, 1'b1, 5, 1'b0);
    wait_idle(200);
    chk("reposition_coil", int'(coil_o), int'(4'b1100));

    // 2: reverse full-step from idx 1, wrapping through 7
    coil_log.delete(); log_en = 1;
    start_run(4, 1'b0, 1'b0, 7, 1'b0);
    wait_idle(400);
    log_en = 0;
    check_log("t2_coil", 5, 4'b1100, 4'b1001, 4'b0011, 4'b0110, 4'b1100);
    chk("t2_starts", cnt_start, 4);

    // 3: zero-step request with hold=0: done next cycle, no start, coil stays off
    set_hold(1'b0);
    coil_log.delete(); log_en = 1;
    start_run(0, 1'b1, 1'b1, 5, 1'b0);
    wait_idle(50);
    log_en = 0;
    check_log("t3_coil", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("t3_starts", cnt_start, 0);
    chk("t3_dones", cnt_done, 1);

    // 4: timer stuck low -> err after TMO_MAX full cycles past ISSUE, then cleared by next go
    set_hold(1'b1);
    start_run(1, 1'b1, 1'b1, 1, 1'b1);
    @(negedge spd_i);
    chk("t4_issue", int'(tmr_start_o), 1);
    n = 0;
    while (!err_o && n < TMO + 50) begin
      @(negedge spd_i);
      n++;
    end
    chk("t4_err_latency", n, TMO + 1);
    chk("t4_idle", int'(busy_o), 0);
    wait_idle(50);
    chk("t4_err_sticky", int'(err_o), 1);
    start_run(1, 1'b1, 1'b1, 3, 1'b0);
    wait_idle(100);
    chk("t4_err_cleared", int'(err_o), 0);
    chk("t4_dones", cnt_done, 1);

    // 5: reset during WAIT_OFF of step 2 of 5
    start_run(5, 1'b1, 1'b1, 6, 1'b0);
    n = 0;
    while (m_r < 14 && n < 200) begin
      @(negedge spd_i);
      n++;
    end
    chk_en = 0;
    #2 rst_i = 1'b0;
    #1;
    chk("t5_coil", int'(coil_o), 0);
    chk("t5_busy", int'(busy_o), 0);
    chk("t5_start", int'(tmr_start_o), 0);
    repeat (3) begin
      @(negedge spd_i);
      chk("t5_no_done", int'(done_o), 0);
      chk("t5_busy_held", int'(busy_o), 0);
    end
    m_run = 0; m_idx = 0; m_err = 0;
    @(posedge spd_i); #2;
    rst_i = 1'b1;
    @(posedge spd_i); #1;
    chk_en = 1;
    repeat (2) @(negedge spd_i);
    start_run(2, 1'b1, 1'b0, 4, 1'b0);
    wait_idle(200);
    chk("t5_fresh_coil", int'(coil_o), int'(4'b0010));

    // 6: go pulses while busy are ignored; hold selects idle coil drive
    start_run(3, 1'b1, 1'b0, 8, 1'b0);
    repeat (3) begin
      repeat (6) @(posedge spd_i);
      #1 go_i = 1'b1; n_steps_i = CW'(7);
      @(posedge spd_i); #1 go_i = 1'b0;
    end
    wait_idle(400);
    chk("t6_starts", cnt_start, 3);
    chk("t6_dones", cnt_done, 1);
    chk("t6_hold_coil", int'(coil_o), int'(4'b0100));
    set_hold(1'b0);
    chk("t6_release_coil", int'(coil_o), 0);
    set_hold(1'b1);
    chk("t6_rehold_coil", int'(coil_o), int'(4'b0100));

    // Maximum count for this counter width: 15 steps, no overflow
    start_run(15, 1'b1, 1'b1, 1, 1'b0);
    wait_idle(200);
    chk("max_starts", cnt_start, 15);
    chk("max_dones", cnt_done, 1);
    chk("max_coil", int'(coil_o), int'(4'b1100));

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
